// File: rtl/decode_stage.sv
// decode_stage: RV32 subset decode stage with register file and execute register.
//   Decodes lw, sw, R-type (add/sub/and/or/slt), I-ALU (addi/andi/ori/slti), beq
//   and jal. Anything else decodes to a bubble, meaning all execute controls are zero.
//   Register file: 32x32, two combinational read ports and one write port.
//   Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   de_instr/de_pc/de_pc_plus4  instruction in decode and its PCs
//   ex_flush                    loads a bubble into the execute register
//   wb_we/wb_rd/wb_result       register file write port
//   de_rs1/de_rs2               combinational source indices (hazard unit)
//   ex_*                        registered execute-stage operands and controls
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     de_instr,
  input  logic [XLEN-1:0] de_pc,
  input  logic [XLEN-1:0] de_pc_plus4,
  input  logic            ex_flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic [4:0]      de_rs1,
  output logic [4:0]      de_rs2,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [1:0]      ex_result_src,
  output logic [2:0]      ex_alu_ctrl
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
  } ex_t;

  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rd1, rd2;
  ex_t             ex_d, ex_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = de_instr[6:0];
  assign funct3 = de_instr[14:12];
  assign funct7 = de_instr[31:25];
  assign de_rs1 = de_instr[19:15];
  assign de_rs2 = de_instr[24:20];

  assign imm_i = {{20{de_instr[31]}}, de_instr[31:20]};
  assign imm_s = {{20{de_instr[31]}}, de_instr[31:25], de_instr[11:7]};
  assign imm_b = {{19{de_instr[31]}}, de_instr[31], de_instr[7], de_instr[30:25],
                  de_instr[11:8], 1'b0};
  assign imm_j = {{11{de_instr[31]}}, de_instr[31], de_instr[19:12], de_instr[20],
                  de_instr[30:21], 1'b0};

  // x0 is forced to zero on read, so its storage entry is never consulted.
`ifdef REGFILE_BYPASS_EN
  assign rd1 = (de_rs1 == 5'd0) ? '0 :
               (wb_we && (wb_rd == de_rs1)) ? wb_result : rf_q[de_rs1];
  assign rd2 = (de_rs2 == 5'd0) ? '0 :
               (wb_we && (wb_rd == de_rs2)) ? wb_result : rf_q[de_rs2];
`else
  assign rd1 = (de_rs1 == 5'd0) ? '0 : rf_q[de_rs1];
  assign rd2 = (de_rs2 == 5'd0) ? '0 : rf_q[de_rs2];
`endif

  always_comb begin
    ex_d          = '0;
    ex_d.rd1      = rd1;
    ex_d.rd2      = rd2;
    ex_d.pc       = de_pc;
    ex_d.pc_plus4 = de_pc_plus4;
    ex_d.rs1      = de_rs1;
    ex_d.rs2      = de_rs2;
    ex_d.rd       = de_instr[11:7];
    case (opcode)
      7'b0000011: if (funct3 == 3'b010) begin
        ex_d.reg_write  = 1'b1;
        ex_d.alu_src    = 1'b1;
        ex_d.result_src = 2'b01;
        ex_d.imm        = imm_i;
      end
      7'b0100011: if (funct3 == 3'b010) begin
        ex_d.mem_write = 1'b1;
        ex_d.alu_src   = 1'b1;
        ex_d.imm       = imm_s;
      end
      7'b0110011: begin
        // Only the base encodings are accepted; anything else stays a bubble.
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_ADD; end
            3'b111: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_AND; end
            3'b110: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_OR;  end
            3'b010: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_SLT; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          ex_d.reg_write = 1'b1;
          ex_d.alu_ctrl  = ALU_SUB;
        end
      end
      7'b0010011: begin
        // instr[30] is immediate data here, so addi never becomes a subtract.
        case (funct3)
          3'b000: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_ADD; end
          3'b111: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_AND; end
          3'b110: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_OR;  end
          3'b010: begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = ALU_SLT; end
          default: ;
        endcase
        if (ex_d.reg_write) begin
          ex_d.alu_src = 1'b1;
          ex_d.imm     = imm_i;
        end
      end
      7'b1100011: if (funct3 == 3'b000) begin
        ex_d.branch   = 1'b1;
        ex_d.alu_ctrl = ALU_SUB;
        ex_d.imm      = imm_b;
      end
      7'b1101111: begin
        ex_d.reg_write  = 1'b1;
        ex_d.jump       = 1'b1;
        ex_d.result_src = 2'b10;
        ex_d.imm        = imm_j;
      end
      default: ;
    endcase
  end

  // Reset wins over writeback, so a write coincident with rst is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || ex_flush) ex_q <= '0;
    else                 ex_q <= ex_d;
  end

  assign ex_rd1        = ex_q.rd1;
  assign ex_rd2        = ex_q.rd2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc         = ex_q.pc;
  assign ex_pc_plus4   = ex_q.pc_plus4;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign ex_result_src = ex_q.result_src;
  assign ex_alu_ctrl   = ex_q.alu_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors, a behavioural model checked
// every cycle, and literal expectations at the key points.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, ex_flush, wb_we;
  logic [31:0] de_instr, de_pc, de_pc_plus4, wb_result;
  logic [4:0]  wb_rd;
  logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc, ex_pc_plus4;
  logic        ex_reg_write, ex_mem_write, ex_alu_src, ex_branch, ex_jump;
  logic [1:0]  ex_result_src;
  logic [2:0]  ex_alu_ctrl;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .de_instr(de_instr), .de_pc(de_pc),
    .de_pc_plus4(de_pc_plus4), .ex_flush(ex_flush), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_result(wb_result), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_result_src(ex_result_src), .ex_alu_ctrl(ex_alu_ctrl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_BUB, M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_SLT,
                M_ADDI, M_ANDI, M_ORI, M_SLTI, M_BEQ, M_JAL} mn_t;

  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, asrc, br, jmp;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
  } exp_t;

  logic [31:0] mem [32];
  exp_t        exp_q;
  bit          exp_full  = 0;
  bit          exp_valid = 0;

  function automatic mn_t classify(input logic [31:0] i);
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    if (op == 7'h03 && f3 == 2) return M_LW;
    if (op == 7'h23 && f3 == 2) return M_SW;
    if (op == 7'h63 && f3 == 0) return M_BEQ;
    if (op == 7'h6F) return M_JAL;
    if (op == 7'h33) begin
      if (f7 == 7'h20 && f3 == 0) return M_SUB;
      if (f7 != 0) return M_BUB;
      if (f3 == 0) return M_ADD;
      if (f3 == 7) return M_AND;
      if (f3 == 6) return M_OR;
      if (f3 == 2) return M_SLT;
      return M_BUB;
    end
    if (op == 7'h13) begin
      if (f3 == 0) return M_ADDI;
      if (f3 == 7) return M_ANDI;
      if (f3 == 6) return M_ORI;
      if (f3 == 2) return M_SLTI;
    end
    return M_BUB;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == idx) return wb_result;
`endif
    return mem[idx];
  endfunction

  function automatic exp_t predict(input logic [31:0] i);
    exp_t e;
    mn_t  m = classify(i);
    int   simm;
    e.rd1 = model_read(i[19:15]); e.rd2 = model_read(i[24:20]);
    e.pc = de_pc; e.pc4 = de_pc_plus4;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.rw = 0; e.mw = 0; e.asrc = 0; e.br = 0; e.jmp = 0; e.rsrc = 0; e.alu = 0;
    e.imm = 0;
    case (m)
      M_LW, M_ADDI, M_ANDI, M_ORI, M_SLTI: begin
        simm = int'($signed(i[31:20]));
        e.imm = 32'(simm);
      end
      M_SW: begin
        simm = int'($signed({i[31:25], i[11:7]}));
        e.imm = 32'(simm);
      end
      M_BEQ: begin
        simm = int'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
        e.imm = 32'(simm);
      end
      M_JAL: begin
        simm = int'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
        e.imm = 32'(simm);
      end
      default: ;
    endcase
    case (m)
      M_LW:   begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01; end
      M_SW:   begin e.mw = 1; e.asrc = 1; end
      M_BEQ:  begin e.br = 1; e.alu = 3'b001; end
      M_JAL:  begin e.rw = 1; e.jmp = 1; e.rsrc = 2'b10; end
      M_ADD:  e.rw = 1;
      M_SUB:  begin e.rw = 1; e.alu = 3'b001; end
      M_AND:  begin e.rw = 1; e.alu = 3'b010; end
      M_OR:   begin e.rw = 1; e.alu = 3'b011; end
      M_SLT:  begin e.rw = 1; e.alu = 3'b101; end
      M_ADDI: begin e.rw = 1; e.asrc = 1; end
      M_ANDI: begin e.rw = 1; e.asrc = 1; e.alu = 3'b010; end
      M_ORI:  begin e.rw = 1; e.asrc = 1; e.alu = 3'b011; end
      M_SLTI: begin e.rw = 1; e.asrc = 1; e.alu = 3'b101; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.rd1 = 0; e.rd2 = 0; e.imm = 0; e.pc = 0; e.pc4 = 0;
    e.rs1 = 0; e.rs2 = 0; e.rd = 0;
    e.rw = 0; e.mw = 0; e.asrc = 0; e.br = 0; e.jmp = 0; e.rsrc = 0; e.alu = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q    = zero_exp();
      exp_full = 1;
      for (int k = 0; k < 32; k++) mem[k] = 32'd0;
    end else begin
      if (ex_flush) begin
        exp_q    = zero_exp();
        exp_full = 1;
      end else begin
        exp_q    = predict(de_instr);
        exp_full = (classify(de_instr) != M_BUB);
      end
      if (wb_we && wb_rd != 0) mem[wb_rd] = wb_result;
    end
    exp_valid = 1;
  end

  always @(negedge clk) begin
    chk("de_rs1", {27'd0, de_rs1}, {27'd0, de_instr[19:15]});
    chk("de_rs2", {27'd0, de_rs2}, {27'd0, de_instr[24:20]});
    if (exp_valid) begin
      chk("reg_write",  {31'd0, ex_reg_write}, {31'd0, exp_q.rw});
      chk("mem_write",  {31'd0, ex_mem_write}, {31'd0, exp_q.mw});
      chk("alu_src",    {31'd0, ex_alu_src},   {31'd0, exp_q.asrc});
      chk("branch",     {31'd0, ex_branch},    {31'd0, exp_q.br});
      chk("jump",       {31'd0, ex_jump},      {31'd0, exp_q.jmp});
      chk("result_src", {30'd0, ex_result_src}, {30'd0, exp_q.rsrc});
      chk("alu_ctrl",   {29'd0, ex_alu_ctrl},  {29'd0, exp_q.alu});
      if (exp_full) begin
        chk("ex_rd1",      ex_rd1,      exp_q.rd1);
        chk("ex_rd2",      ex_rd2,      exp_q.rd2);
        chk("ex_imm",      ex_imm,      exp_q.imm);
        chk("ex_pc",       ex_pc,       exp_q.pc);
        chk("ex_pc_plus4", ex_pc_plus4, exp_q.pc4);
        chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, exp_q.rs1});
        chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, exp_q.rs2});
        chk("ex_rd",  {27'd0, ex_rd},  {27'd0, exp_q.rd});
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc_v = 32'h0000_1000;

  task automatic drive(input logic [31:0] instr, input logic flush, input logic r,
                       input logic we, input logic [4:0] rd, input logic [31:0] res);
    de_instr    = instr;
    de_pc       = pc_v;
    de_pc_plus4 = pc_v + 32'd4;
    pc_v        = pc_v + 32'd4;
    ex_flush    = flush;
    rst         = r;
    wb_we       = we;
    wb_rd       = rd;
    wb_result   = res;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  logic [31:0] vec [17];

  initial begin
    rst = 1; ex_flush = 0; wb_we = 0; wb_rd = 0; wb_result = 0;
    de_instr = 0; de_pc = 0; de_pc_plus4 = 0;
    @(posedge clk); #2;
    drive(32'h0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hAAAA_5555);
    chk("rst reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("rst imm",       ex_imm, 32'd0);
    chk("rst pc",        ex_pc, 32'd0);
    chk("rst result_src", {30'd0, ex_result_src}, 32'd0);

    // addi x1,x0,5 while writing x1 = 0x100
    drive(32'h0050_0093, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0100);
    chk("addi imm",      ex_imm, 32'd5);
    chk("addi rd",       {27'd0, ex_rd}, 32'd1);
    chk("addi reg_write", {31'd0, ex_reg_write}, 32'd1);
    chk("addi alu_src",  {31'd0, ex_alu_src}, 32'd1);
    chk("addi alu_ctrl", {29'd0, ex_alu_ctrl}, 32'd0);

    // add x3,x1,x2 with same-cycle write of x2
    drive(32'h0020_81B3, 1'b0, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF);
    chk("add rd1", ex_rd1, 32'h0000_0100);
`ifdef REGFILE_BYPASS_EN
    chk("add rd2 bypass", ex_rd2, 32'hDEAD_BEEF);
`else
    chk("add rd2 no bypass", ex_rd2, 32'd0);
`endif

    drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    drive(32'h0050_0093, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("x0 read", ex_rd1, 32'd0);

    drive(32'hFE00_0EE3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("beq imm",      ex_imm, 32'hFFFF_FFFC);
    chk("beq branch",   {31'd0, ex_branch}, 32'd1);
    chk("beq alu_ctrl", {29'd0, ex_alu_ctrl}, 32'd1);

    // lw x5,8(x1) flushed (writeback to x5 must still land), then unflushed
    drive(32'h0080_A283, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0055);
    chk("flush reg_write",  {31'd0, ex_reg_write}, 32'd0);
    chk("flush result_src", {30'd0, ex_result_src}, 32'd0);
    chk("flush imm",        ex_imm, 32'd0);
    chk("flush rd1",        ex_rd1, 32'd0);
    chk("flush pc",         ex_pc, 32'd0);
    drive(32'h0080_A283, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("lw result_src", {30'd0, ex_result_src}, 32'd1);
    chk("lw imm",        ex_imm, 32'd8);
    chk("lw rd1",        ex_rd1, 32'h0000_0100);

    vec[0]  = enc_s(12'h004, 5'd5, 5'd1);
    vec[1]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
    vec[2]  = enc_r(7'h00, 5'd5, 5'd1, 3'd7, 5'd6);
    vec[3]  = enc_r(7'h00, 5'd5, 5'd2, 3'd6, 5'd7);
    vec[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd8);
    vec[5]  = enc_i(12'h0FF, 5'd2, 3'd7, 5'd9, 7'h13);
    vec[6]  = enc_i(12'hFFF, 5'd5, 3'd6, 5'd10, 7'h13);
    vec[7]  = enc_i(12'h800, 5'd1, 3'd2, 5'd11, 7'h13);
    vec[8]  = enc_i(12'h400, 5'd1, 3'd0, 5'd12, 7'h13);
    vec[9]  = enc_j(21'h1F_FFF0, 5'd1);
    vec[10] = enc_j(21'h00_0800, 5'd0);
    vec[11] = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd13);
    vec[12] = enc_i(12'h003, 5'd1, 3'd1, 5'd14, 7'h13);
    vec[13] = enc_i(12'h004, 5'd1, 3'd0, 5'd15, 7'h03);
    vec[14] = enc_r(7'h21, 5'd2, 5'd1, 3'd0, 5'd16);
    vec[15] = {7'h00, 5'd2, 5'd1, 3'd1, 5'd8, 7'h63};
    vec[16] = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd17);
    for (int v = 0; v < 17; v++) begin
      drive(vec[v], 1'b0, 1'b0, v[0], 5'(v + 3), $urandom);
      if (v == 0) chk("sw rd2 after flushed write", ex_rd2, 32'h0000_0055);
      if (v == 0) chk("sw imm", ex_imm, 32'd4);
      if (v == 8) chk("addi never subtracts", {29'd0, ex_alu_ctrl}, 32'd0);
      if (v == 9) chk("jal imm", ex_imm, 32'hFFFF_FFF0);
    end

    drive(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("illegal reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("illegal mem_write", {31'd0, ex_mem_write}, 32'd0);
    chk("illegal jump",      {31'd0, ex_jump}, 32'd0);
    chk("illegal branch",    {31'd0, ex_branch}, 32'd0);

    drive(32'h0080_A283, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_0077);
    chk("rst+flush reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("rst+flush pc",        ex_pc, 32'd0);
    drive(enc_i(12'h000, 5'd7, 3'd0, 5'd8, 7'h13), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("write under rst dropped", ex_rd1, 32'd0);
    drive(32'h0020_81B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("rf cleared by rst", ex_rd2, 32'd0);
    drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
